onebit_ctrl: RTL and testbench

Synthesizable phase sequencer driving the control pins of the one-bit CIM SRAM cell + sense-amp column: preb, w_en, write_bit, sampleb, SAE, WL, WLB. It accepts write / read-Q / read-QB requests over a valid/ready handshake. It generates the precharge → sample → sense → reset phase timing in hardware, with a fixed cycle count per phase, and returns the sensed bit. It sits between the digital macro controller and the analog bit-cell/SA array, replacing bench-driven phase stimulus.

---
 rtl/onebit_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_onebit_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/onebit_ctrl.sv
// Phase sequencer for the one-bit CIM SRAM cell and its sense-amp column.
// Runs write / read-Q / read-QB requests through timed phases and returns the sensed bit.
module onebit_ctrl #(
  parameter int PH_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic       req_fast,
  input  logic       req_wbit,
  input  logic       sa_out,
  output logic       preb,
  output logic       w_en,
  output logic       write_bit,
  output logic       sampleb,
  output logic       SAE,
  output logic       WL,
  output logic       WLB,
  output logic       rsp_valid,
  output logic       rsp_data,
  output logic       rsp_err
);

  localparam int CW = $clog2(PH_CYC + 1);
  localparam logic [CW-1:0] RELOAD = CW'(PH_CYC - 1);

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_RQ  = 2'b01;
  localparam logic [1:0] OP_RQB = 2'b10;

  if (PH_CYC < 1 || PH_CYC > 255) begin : g_bad_ph_cyc
    $error("onebit_ctrl: PH_CYC out of range 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_PRE, S_SAMPLE, S_SENSE, S_SMPSNS, S_RST, S_ERR
  } state_t;

  state_t state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0] op_reg, op_next;
  logic fast_reg, fast_next;
  logic wbit_reg, wbit_next;
  logic cap_reg, cap_next;

  logic preb_reg, preb_next;
  logic w_en_reg, w_en_next;
  logic write_bit_reg, write_bit_next;
  logic sampleb_reg, sampleb_next;
  logic sae_reg, sae_next;
  logic wl_reg, wl_next;
  logic wlb_reg, wlb_next;
  logic req_ready_reg, req_ready_next;
  logic rsp_valid_reg, rsp_valid_next;
  logic rsp_data_reg, rsp_data_next;
  logic rsp_err_reg, rsp_err_next;

  logic accept;
  logic phase_done;

  assign accept     = req_valid & req_ready_reg & (state_reg == S_IDLE);
  assign phase_done = (cnt_reg == '0);

  // State and output registers; every control pin comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= RELOAD;
      op_reg        <= OP_WR;
      fast_reg      <= 1'b0;
      wbit_reg      <= 1'b0;
      cap_reg       <= 1'b0;
      preb_reg      <= 1'b0;
      w_en_reg      <= 1'b0;
      write_bit_reg <= 1'b0;
      sampleb_reg   <= 1'b1;
      sae_reg       <= 1'b0;
      wl_reg        <= 1'b0;
      wlb_reg       <= 1'b0;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= 1'b0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      op_reg        <= op_next;
      fast_reg      <= fast_next;
      wbit_reg      <= wbit_next;
      cap_reg       <= cap_next;
      preb_reg      <= preb_next;
      w_en_reg      <= w_en_next;
      write_bit_reg <= write_bit_next;
      sampleb_reg   <= sampleb_next;
      sae_reg       <= sae_next;
      wl_reg        <= wl_next;
      wlb_reg       <= wlb_next;
      req_ready_reg <= req_ready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          case (req_op)
            OP_WR:         state_next = S_WRITE;
            OP_RQ, OP_RQB: state_next = S_PRE;
            default:       state_next = S_ERR;
          endcase
        end
      end
      S_WRITE:  if (phase_done) state_next = S_RST;
      S_PRE:    if (phase_done) state_next = fast_reg ? S_SMPSNS : S_SAMPLE;
      S_SAMPLE: if (phase_done) state_next = S_SENSE;
      S_SENSE:  if (phase_done) state_next = S_RST;
      S_SMPSNS: if (phase_done) state_next = S_RST;
      S_RST:    if (phase_done) state_next = S_IDLE;
      S_ERR:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase

    op_next   = accept ? req_op   : op_reg;
    fast_next = accept ? req_fast : fast_reg;
    wbit_next = accept ? req_wbit : wbit_reg;

    // Sense result is taken at the edge that leaves the sensing phase.
    cap_next = accept ? 1'b0 : cap_reg;
    if ((state_reg == S_SENSE || state_reg == S_SMPSNS) && phase_done)
      cap_next = sa_out;

    if (state_next != state_reg || state_reg == S_IDLE)
      cnt_next = RELOAD;
    else
      cnt_next = cnt_reg - CW'(1);
  end

  // Output levels are decoded from the state being entered so they appear at the entry edge.
  always_comb begin
    preb_next      = 1'b0;
    w_en_next      = 1'b0;
    write_bit_next = 1'b0;
    sampleb_next   = 1'b1;
    sae_next       = 1'b0;
    wl_next        = 1'b0;
    wlb_next       = 1'b0;
    case (state_next)
      S_WRITE: begin
        preb_next      = 1'b1;
        w_en_next      = 1'b1;
        write_bit_next = wbit_next;
        wl_next        = 1'b1;
        wlb_next       = 1'b1;
      end
      S_PRE: write_bit_next = write_bit_reg;
      S_SAMPLE, S_SMPSNS: begin
        preb_next    = 1'b1;
        sampleb_next = 1'b0;
        sae_next     = (state_next == S_SMPSNS);
        wl_next      = (op_next == OP_RQ);
        wlb_next     = (op_next == OP_RQB);
      end
      S_SENSE: begin
        preb_next = 1'b1;
        sae_next  = 1'b1;
      end
      default: ;
    endcase

    req_ready_next = (state_next == S_IDLE);
    rsp_valid_next = ((state_reg == S_RST) && phase_done) || (state_reg == S_ERR);
    rsp_err_next   = (state_reg == S_ERR);
    rsp_data_next  = 1'b0;
    if (state_reg == S_RST && phase_done)
      rsp_data_next = (op_reg == OP_WR) ? wbit_reg : (cap_reg ^ (op_reg == OP_RQB));
  end

  assign preb      = preb_reg;
  assign w_en      = w_en_reg;
  assign write_bit = write_bit_reg;
  assign sampleb   = sampleb_reg;
  assign SAE       = sae_reg;
  assign WL        = wl_reg;
  assign WLB       = wlb_reg;
  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_onebit_ctrl.sv
// Bench for onebit_ctrl: directed requests with per-cycle pin checks and a response scoreboard.
module tb_onebit_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [1:0] req_op = 2'b00;
  logic req_fast = 1'b0;
  logic req_wbit = 1'b0;
  logic sa_out = 1'b0;
  logic preb, w_en, write_bit, sampleb, SAE, WL, WLB;
  logic rsp_valid, rsp_data, rsp_err;

  onebit_ctrl #(.PH_CYC(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_fast(req_fast), .req_wbit(req_wbit), .sa_out(sa_out),
    .preb(preb), .w_en(w_en), .write_bit(write_bit), .sampleb(sampleb),
    .SAE(SAE), .WL(WL), .WLB(WLB),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // {preb, w_en, write_bit, sampleb, SAE, WL, WLB, req_ready}
  logic [7:0] pins;
  assign pins = {preb, w_en, write_bit, sampleb, SAE, WL, WLB, req_ready};

  localparam logic [7:0] P_IDLE  = 8'b0001_0001;
  localparam logic [7:0] P_LOW   = 8'b0001_0000;
  localparam logic [7:0] P_WR1   = 8'b1111_0110;
  localparam logic [7:0] P_WR0   = 8'b1101_0110;
  localparam logic [7:0] P_SMPQ  = 8'b1000_0100;
  localparam logic [7:0] P_SMPQB = 8'b1000_0010;
  localparam logic [7:0] P_SNS   = 8'b1001_1000;
  localparam logic [7:0] P_FASTQ = 8'b1000_1100;

  typedef struct {
    logic d;
    logic e;
    int   c;
  } exp_t;

  exp_t q[$];
  exp_t h;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pop one expectation per response pulse and verify cycle, data and error flag.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp at cycle %0d: got rsp_valid=1, expected 0", cyc);
      end else begin
        h = q.pop_front();
        check("rsp_cycle", cyc, h.c);
        check("rsp_data", rsp_data, h.d);
        check("rsp_err", rsp_err, h.e);
      end
    end else if (q.size() > 0 && cyc > q[0].c) begin
      h = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_rsp at cycle %0d: got no response, expected one at cycle %0d", cyc, h.c);
    end
  end

  task automatic send(input logic [1:0] op, input logic fast, input logic wbit,
                      input int lat, input logic ed, input logic ee, input bit push);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_fast  = fast;
    req_wbit  = wbit;
    if (push) q.push_back('{ed, ee, cyc + 1 + lat});
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic expect_phase(input string name, input logic [7:0] exp, input int n);
    repeat (n) begin
      @(negedge clk);
      check(name, pins, exp);
    end
  endtask

  task automatic read_phases(input logic [7:0] smp);
    expect_phase("pre", P_LOW, 2);
    expect_phase("sample", smp, 2);
    expect_phase("sense", P_SNS, 2);
    expect_phase("rst_ph", P_LOW, 2);
    expect_phase("idle", P_IDLE, 1);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog at cycle %0d: got no finish, expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_pins", pins, P_IDLE);
    check("reset_rsp", {rsp_valid, rsp_data, rsp_err}, 3'b000);
    rst = 1'b0;

    // Write 1
    send(2'b00, 1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b1);
    expect_phase("write1", P_WR1, 2);
    expect_phase("wr_rst", P_LOW, 2);
    expect_phase("idle", P_IDLE, 1);

    // Read Q, normal, sa_out=1
    sa_out = 1'b1;
    send(2'b01, 1'b0, 1'b0, 8, 1'b1, 1'b0, 1'b1);
    read_phases(P_SMPQ);

    // Read QB, normal, sa_out=0 -> inverted to 1
    sa_out = 1'b0;
    send(2'b10, 1'b0, 1'b0, 8, 1'b1, 1'b0, 1'b1);
    read_phases(P_SMPQB);

    // Read Q fast, sa_out=0
    send(2'b01, 1'b1, 1'b0, 6, 1'b0, 1'b0, 1'b1);
    expect_phase("pre", P_LOW, 2);
    expect_phase("smpsns", P_FASTQ, 2);
    expect_phase("rst_ph", P_LOW, 2);
    expect_phase("idle", P_IDLE, 1);

    // Write 0 with fast set, which writes ignore
    send(2'b00, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b1);
    expect_phase("write0", P_WR0, 2);
    expect_phase("wr_rst", P_LOW, 2);
    expect_phase("idle", P_IDLE, 1);

    // Illegal op, then a read held valid and accepted at the end of the error pulse
    send(2'b11, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b1);
    q.push_back('{1'b1, 1'b0, cyc + 10});
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_fast  = 1'b0;
    sa_out    = 1'b1;
    expect_phase("err_ph", P_LOW, 1);
    expect_phase("err_idle", P_IDLE, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    read_phases(P_SMPQ);

    // Reset during SAMPLE, with a write request presented alongside the reset
    send(2'b01, 1'b0, 1'b0, 8, 1'b0, 1'b0, 1'b0);
    expect_phase("pre", P_LOW, 2);
    expect_phase("sample", P_SMPQ, 1);
    rst       = 1'b1;
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_wbit  = 1'b1;
    @(negedge clk);
    check("abort_pins", pins, P_IDLE);
    check("abort_rsp", {rsp_valid, rsp_data, rsp_err}, 3'b000);
    rst       = 1'b0;
    req_valid = 1'b0;
    expect_phase("post_abort", P_IDLE, 3);

    // Read QB after the abort, sa_out=1 -> 0
    send(2'b10, 1'b0, 1'b0, 8, 1'b0, 1'b0, 1'b1);
    read_phases(P_SMPQB);

    repeat (4) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
